// File: rtl/fake_trigger_axis_stall_detect_pkg.sv
// Shared types and widths for the AXI-stream stall detector.
// The report FSM states and counter widths live here so sub-blocks agree on them.
package fake_trigger_axis_stall_detect_pkg;
   localparam int TS_W   = 32;
   localparam int MISS_W = 8;
   localparam int CHAN_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REPORT = 2'd1,
      DRAIN  = 2'd2
   } rpt_state_e;
endpackage

// File: rtl/fake_trigger_stall_counter.sv
// Per-channel stall run-length counter and registered block flag.
// The flag rises once THRESH consecutive stalled cycles have been seen.
module fake_trigger_stall_counter #(
   parameter int THRESH = 16,
   parameter int CNT_W  = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic dir,
   input  logic tvalid,
   input  logic tready,
   output logic block
);
   localparam logic [CNT_W:0]   THRESH_EXT = (CNT_W+1)'(THRESH);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   logic             stall;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   cnt_inc;

   // Sink side stalls when starved, source side when backpressured.
   assign stall   = dir ? (tready & ~tvalid) : (tvalid & ~tready);
   assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt   <= '0;
         block <= 1'b0;
      end else begin
         block <= stall && (cnt_inc >= THRESH_EXT);
         if (!stall)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt_inc[CNT_W-1:0];
      end
   end
endmodule

// File: rtl/fake_trigger_axis_stall_detect.sv
// Watches NCHAN AXI-stream taps for long stalls and reports the first block
// (channel + timestamp) over a valid/ready handshake, counting missed ones.
module fake_trigger_axis_stall_detect
   import fake_trigger_axis_stall_detect_pkg::*;
#(
   parameter int NCHAN  = 5,
   parameter int THRESH = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NCHAN-1:0]  chan_dir,
   input  logic [NCHAN-1:0]  tvalid,
   input  logic [NCHAN-1:0]  tready,
   output logic [NCHAN-1:0]  axis_block_sigs,
   output logic              rpt_valid,
   input  logic              rpt_ready,
   output logic [CHAN_W-1:0] rpt_chan,
   output logic [TS_W-1:0]   rpt_time,
   output logic [MISS_W-1:0] rpt_missed
);
   // state  | meaning
   // IDLE   | waiting for any block flag
   // REPORT | report presented, held until accepted
   // DRAIN  | report accepted, waiting for all flags to clear

   rpt_state_e        state, state_next;
   logic [TS_W-1:0]   ts;
   logic [NCHAN-1:0]  blk_prev;
   logic [CHAN_W-1:0] low_idx;
   logic              any_blk, any_rise, capture, miss_en;

   for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
      fake_trigger_stall_counter #(
         .THRESH (THRESH),
         .CNT_W  (CNT_W)
      ) u_cnt (
         .clock  (clock),
         .reset  (reset),
         .dir    (chan_dir[gi]),
         .tvalid (tvalid[gi]),
         .tready (tready[gi]),
         .block  (axis_block_sigs[gi])
      );
   end

   assign any_blk  = |axis_block_sigs;
   assign any_rise = |(axis_block_sigs & ~blk_prev);
   assign miss_en  = any_rise && (state != IDLE);

   always_comb begin
      low_idx = '0;
      for (int i = NCHAN-1; i >= 0; i--)
         if (axis_block_sigs[i]) low_idx = CHAN_W'(i);
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      rpt_valid  = 1'b0;
      case (state)
         IDLE: if (any_blk) begin
            state_next = REPORT;
            capture    = 1'b1;
         end
         REPORT: begin
            rpt_valid = 1'b1;
            if (rpt_ready) state_next = DRAIN;
         end
         DRAIN: if (!any_blk) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ts         <= '0;
         blk_prev   <= '0;
         rpt_chan   <= '0;
         rpt_time   <= '0;
         rpt_missed <= '0;
      end else begin
         ts       <= ts + TS_W'(1);
         blk_prev <= axis_block_sigs;
         if (capture) begin
            rpt_chan <= low_idx;
            rpt_time <= ts;
         end
         if (miss_en && (rpt_missed != '1))
            rpt_missed <= rpt_missed + MISS_W'(1);
      end
   end
endmodule

// File: tb/tb_fake_trigger_axis_stall_detect.sv
// Bench for the stall detector: directed vector table, timestamp wrap and reset
// sequences, then random traffic, all against a run-length reference model.
module tb_fake_trigger_axis_stall_detect;
   localparam int NCHAN  = 5;
   localparam int THRESH = 16;
   localparam int CNT_W  = 16;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [NCHAN-1:0] chan_dir = 5'b00100;
   logic [NCHAN-1:0] tvalid = '0;
   logic [NCHAN-1:0] tready = '0;
   logic             rpt_ready = 1'b0;
   logic [NCHAN-1:0] axis_block_sigs;
   logic             rpt_valid;
   logic [2:0]       rpt_chan;
   logic [31:0]      rpt_time;
   logic [7:0]       rpt_missed;

   int checks = 0;
   int failures = 0;

   // reference model state (what the outputs must be after the latest edge)
   int          run [NCHAN];
   logic [4:0]  m_blk = '0, m_prev = '0;
   logic [31:0] m_ts = '0, m_time = '0;
   int          m_mode = 0;
   logic [2:0]  m_chan = '0;
   int          m_missed = 0;
   int          preset_seq = 0, seen_seq = 0;
   logic [31:0] preset_val = '0;

   typedef struct {
      logic [4:0] tv;
      logic [4:0] tr;
      logic       rr;
      int         wait_n;
      logic [4:0] blk;
      logic       valid;
      logic [2:0] chan;
      logic [7:0] missed;
   } vec_t;
   vec_t vecs [22];

   fake_trigger_axis_stall_detect #(
      .NCHAN  (NCHAN),
      .THRESH (THRESH),
      .CNT_W  (CNT_W)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .chan_dir        (chan_dir),
      .tvalid          (tvalid),
      .tready          (tready),
      .axis_block_sigs (axis_block_sigs),
      .rpt_valid       (rpt_valid),
      .rpt_ready       (rpt_ready),
      .rpt_chan        (rpt_chan),
      .rpt_time        (rpt_time),
      .rpt_missed      (rpt_missed)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One rising edge as seen by the rules: run lengths, report state, misses.
   task automatic model_edge();
      logic [4:0] nb;
      logic       stall;
      nb = '0;
      if (preset_seq != seen_seq) begin
         m_ts     = preset_val;
         seen_seq = preset_seq;
      end
      if (reset) begin
         for (int i = 0; i < NCHAN; i++) run[i] = 0;
         m_blk = '0; m_prev = '0; m_ts = '0; m_time = '0;
         m_mode = 0; m_chan = '0; m_missed = 0;
      end else begin
         for (int i = 0; i < NCHAN; i++) begin
            stall = chan_dir[i] ? (tready[i] && !tvalid[i]) : (tvalid[i] && !tready[i]);
            if (stall) begin
               run[i]++;
               nb[i] = (run[i] >= THRESH);
            end else begin
               run[i] = 0;
            end
         end
         if (m_mode != 0 && (m_blk & ~m_prev) != 0 && m_missed < 255) m_missed++;
         case (m_mode)
            0: if (m_blk != 0) begin
                  m_mode = 1;
                  m_time = m_ts;
                  for (int i = NCHAN-1; i >= 0; i--) if (m_blk[i]) m_chan = 3'(i);
               end
            1: if (rpt_ready) m_mode = 2;
            default: if (m_blk == 0) m_mode = 0;
         endcase
         m_prev = m_blk;
         m_blk  = nb;
         m_ts   = m_ts + 32'd1;
      end
   endtask

   task automatic model_compare();
      check("model_blk", 32'(axis_block_sigs), 32'(m_blk));
      check("model_valid", 32'(rpt_valid), 32'(m_mode == 1));
      if (m_mode == 1) begin
         check("model_chan", 32'(rpt_chan), 32'(m_chan));
         check("model_time", rpt_time, m_time);
      end
      check("model_missed", 32'(rpt_missed), 32'(m_missed));
   endtask

   task automatic cycle();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      model_compare();
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      for (int i = 0; i < NCHAN; i++) run[i] = 0;
      //           tv        tr       rr  wait blk     vld chan missed
      vecs[0]  = '{5'b00001, 5'b00000, 0, 15, 5'b00000, 0, 0, 0};
      vecs[1]  = '{5'b00001, 5'b00000, 0,  1, 5'b00001, 0, 0, 0};
      vecs[2]  = '{5'b00001, 5'b00000, 0,  1, 5'b00001, 1, 0, 0};
      vecs[3]  = '{5'b00001, 5'b00000, 1,  1, 5'b00001, 0, 0, 0};
      vecs[4]  = '{5'b00001, 5'b00001, 0,  1, 5'b00000, 0, 0, 0};
      vecs[5]  = '{5'b00000, 5'b00000, 0,  2, 5'b00000, 0, 0, 0};
      vecs[6]  = '{5'b00000, 5'b00100, 0, 15, 5'b00000, 0, 0, 0};
      vecs[7]  = '{5'b00100, 5'b00100, 0,  1, 5'b00000, 0, 0, 0};
      vecs[8]  = '{5'b00000, 5'b00100, 0, 15, 5'b00000, 0, 0, 0};
      vecs[9]  = '{5'b00000, 5'b00000, 0,  1, 5'b00000, 0, 0, 0};
      vecs[10] = '{5'b01010, 5'b00000, 0, 16, 5'b01010, 0, 0, 0};
      vecs[11] = '{5'b01010, 5'b00000, 0,  1, 5'b01010, 1, 1, 0};
      vecs[12] = '{5'b01010, 5'b00000, 0, 19, 5'b01010, 1, 1, 0};
      vecs[13] = '{5'b01010, 5'b00000, 1,  1, 5'b01010, 0, 0, 0};
      vecs[14] = '{5'b01000, 5'b00000, 0,  1, 5'b01000, 0, 0, 0};
      vecs[15] = '{5'b11000, 5'b00000, 0, 16, 5'b11000, 0, 0, 0};
      vecs[16] = '{5'b11000, 5'b00000, 0,  1, 5'b11000, 0, 0, 1};
      vecs[17] = '{5'b00000, 5'b00000, 0,  1, 5'b00000, 0, 0, 1};
      vecs[18] = '{5'b00001, 5'b00000, 0, 16, 5'b00001, 0, 0, 1};
      vecs[19] = '{5'b00001, 5'b00000, 0,  1, 5'b00001, 1, 0, 1};
      vecs[20] = '{5'b00001, 5'b00000, 1,  1, 5'b00001, 0, 0, 1};
      vecs[21] = '{5'b00000, 5'b00000, 0,  2, 5'b00000, 0, 0, 1};

      @(negedge clock);
      cycles(3);
      reset = 1'b0;
      check("reset_blk", 32'(axis_block_sigs), 32'd0);
      check("reset_valid", 32'(rpt_valid), 32'd0);
      check("reset_missed", 32'(rpt_missed), 32'd0);
      check("reset_time", rpt_time, 32'd0);

      foreach (vecs[v]) begin
         tvalid = vecs[v].tv;
         tready = vecs[v].tr;
         rpt_ready = vecs[v].rr;
         cycles(vecs[v].wait_n);
         check($sformatf("vec%0d_blk", v), 32'(axis_block_sigs), 32'(vecs[v].blk));
         check($sformatf("vec%0d_valid", v), 32'(rpt_valid), 32'(vecs[v].valid));
         if (vecs[v].valid)
            check($sformatf("vec%0d_chan", v), 32'(rpt_chan), 32'(vecs[v].chan));
         check($sformatf("vec%0d_missed", v), 32'(rpt_missed), 32'(vecs[v].missed));
      end

      // timestamp wrap: preset near the top, block detected after the wrap
      force dut.ts = 32'hFFFF_FFF8;
      #1;
      release dut.ts;
      preset_val = 32'hFFFF_FFF8;
      preset_seq++;
      tvalid = 5'b00001;
      cycles(17);
      check("wrap_valid", 32'(rpt_valid), 32'd1);
      check("wrap_time", rpt_time, 32'h0000_0008);
      rpt_ready = 1'b1;
      cycle();
      tvalid = '0;
      rpt_ready = 1'b0;
      cycles(2);

      // reset in mid-REPORT with the stall held through it
      tvalid = 5'b00001;
      cycles(17);
      check("prerst_valid", 32'(rpt_valid), 32'd1);
      reset = 1'b1;
      cycle();
      check("rst_valid", 32'(rpt_valid), 32'd0);
      check("rst_blk", 32'(axis_block_sigs), 32'd0);
      check("rst_chan", 32'(rpt_chan), 32'd0);
      check("rst_time", rpt_time, 32'd0);
      check("rst_missed", 32'(rpt_missed), 32'd0);
      cycle();
      reset = 1'b0;
      cycles(15);
      check("post_rst_blk_early", 32'(axis_block_sigs), 32'd0);
      cycle();
      check("post_rst_blk_rise", 32'(axis_block_sigs), 32'd1);
      tvalid = '0;
      cycles(3);

      // random traffic, slow-changing taps so long stalls actually occur
      chan_dir = 5'($urandom);
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < NCHAN; i++) begin
            if ($urandom_range(0, 23) == 0) tvalid[i] = 1'($urandom);
            if ($urandom_range(0, 23) == 0) tready[i] = 1'($urandom);
         end
         rpt_ready = ($urandom_range(0, 7) == 0);
         reset = ($urandom_range(0, 999) == 0);
         cycle();
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
